// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the hazard stall controller: Tuse/Tnew encodings,
// mult/div latency defaults, the mult/div tracker state type and the
// per-operand hazard compare.
package hazard_stall_ctrl_pkg;

   localparam logic [1:0] TUSE_NONE = 2'd3;

   localparam logic [1:0] TNEW_0 = 2'd0;
   localparam logic [1:0] TNEW_1 = 2'd1;
   localparam logic [1:0] TNEW_2 = 2'd2;

   localparam int MULT_CYC_DEF = 5;
   localparam int DIV_CYC_DEF  = 10;
   localparam int CNT_W_DEF    = 4;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_t;

   // One source operand against one producer stage. $0 never stalls, and
   // TUSE_NONE (3) can never be less than a 2-bit Tnew, so unread operands
   // drop out without a special case.
   function automatic logic src_hazard(
      input logic [4:0] src,
      input logic [1:0] tuse,
      input logic [4:0] wa,
      input logic       we,
      input logic [1:0] tnew
   );
      return (src != 5'd0) && we && (src == wa) && (tuse < tnew);
   endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_tracker.sv
// Occupancy tracker for the multi-cycle mult/div unit. A start loads the
// countdown with the op latency; md_busy is registered and stays high until
// the count expires. A start while busy reloads (last start wins).
//
// state   | meaning
// --------+--------------------------------------------
// MD_IDLE | unit free, cnt = 0
// MD_BUSY | unit occupied, cnt = remaining busy cycles
module md_busy_tracker
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int MULT_CYC = MULT_CYC_DEF,
   parameter int DIV_CYC  = DIV_CYC_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic md_start_E,
   input  logic md_is_div_E,
   output logic md_busy
);

   md_state_t        state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] latency;

   assign latency = md_is_div_E ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);

   // Single FSM: state, countdown and the registered busy flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= MD_IDLE;
         cnt     <= '0;
         md_busy <= 1'b0;
      end else begin
         case (state)
            MD_IDLE: begin
               if (md_start_E) begin
                  cnt     <= latency;
                  state   <= MD_BUSY;
                  md_busy <= 1'b1;
               end
            end
            MD_BUSY: begin
               if (md_start_E) begin
                  cnt     <= latency;
                  md_busy <= 1'b1;
               end else if (cnt <= CNT_W'(1)) begin
                  // <= rather than == so a stray zero count cannot wrap.
                  cnt     <= '0;
                  state   <= MD_IDLE;
                  md_busy <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               state   <= MD_IDLE;
               cnt     <= '0;
               md_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline. Compares D-stage operand
// demand (Tuse) against E/M producer readiness (Tnew), adds the mult/div
// occupancy hazard, and drives PC / IF-ID enables and the ID/EX bubble clear.
// The stall path is purely combinational.
// Optional build macro STALL_STATS_EN adds saturating stall counters.
module hazard_stall_ctrl
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int MULT_CYC = MULT_CYC_DEF,
   parameter int DIV_CYC  = DIV_CYC_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  rs_D,
   input  logic [4:0]  rt_D,
   input  logic [1:0]  Tuse_rs_D,
   input  logic [1:0]  Tuse_rt_D,
   input  logic        md_use_D,
   input  logic [4:0]  regWA_E,
   input  logic        RegWrite_E,
   input  logic [1:0]  Tnew_E,
   input  logic [4:0]  regWA_M,
   input  logic        RegWrite_M,
   input  logic [1:0]  Tnew_M,
   input  logic        md_start_E,
   input  logic        md_is_div_E,
`ifdef STALL_STATS_EN
   output logic [31:0] stall_cnt,
   output logic [31:0] md_stall_cnt,
`endif
   output logic        en_pc,
   output logic        en12,
   output logic        clr_ex,
   output logic        md_busy,
   output logic        stall
);

   logic reg_hazard;
   logic md_hazard;

   md_busy_tracker #(
      .MULT_CYC (MULT_CYC),
      .DIV_CYC  (DIV_CYC),
      .CNT_W    (CNT_W)
   ) u_md_busy_tracker (
      .clk         (clk),
      .reset       (reset),
      .md_start_E  (md_start_E),
      .md_is_div_E (md_is_div_E),
      .md_busy     (md_busy)
   );

   // Register hazards: each source against each producer stage, all ORed.
   always_comb begin
      reg_hazard = src_hazard(rs_D, Tuse_rs_D, regWA_E, RegWrite_E, Tnew_E)
                 | src_hazard(rs_D, Tuse_rs_D, regWA_M, RegWrite_M, Tnew_M)
                 | src_hazard(rt_D, Tuse_rt_D, regWA_E, RegWrite_E, Tnew_E)
                 | src_hazard(rt_D, Tuse_rt_D, regWA_M, RegWrite_M, Tnew_M);
   end

   // The issue cycle itself is covered by md_start_E since md_busy lags it.
   assign md_hazard = md_use_D & (md_busy | md_start_E);

   assign stall  = reg_hazard | md_hazard;
   assign en_pc  = ~stall;
   assign en12   = ~stall;
   assign clr_ex = stall;

`ifdef STALL_STATS_EN
   // Saturating cycle counters for total stalls and mult/div stalls.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt    <= '0;
         md_stall_cnt <= '0;
      end else begin
         if (stall && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
         if (md_hazard && (md_stall_cnt != 32'hFFFF_FFFF))
            md_stall_cnt <= md_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: stimulus pushes expected outputs
// from a behavioural model, a negedge monitor pops and compares.
module tb_hazard_stall_ctrl;

   typedef struct {
      logic       reset;
      logic [4:0] rs, rt;
      logic [1:0] tuse_rs, tuse_rt;
      logic       md_use;
      logic [4:0] wa_e, wa_m;
      logic       we_e, we_m;
      logic [1:0] tnew_e, tnew_m;
      logic       md_start, md_div;
   } stim_t;

   typedef struct {
      logic        stall;
      logic        md_busy;
      logic [31:0] sc;
      logic [31:0] msc;
      string       tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rs_D, rt_D, regWA_E, regWA_M;
   logic [1:0]  Tuse_rs_D, Tuse_rt_D, Tnew_E, Tnew_M;
   logic        md_use_D, RegWrite_E, RegWrite_M, md_start_E, md_is_div_E;
   logic        en_pc, en12, clr_ex, md_busy, stall;
`ifdef STALL_STATS_EN
   logic [31:0] stall_cnt, md_stall_cnt;
`endif

   hazard_stall_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .rs_D        (rs_D),
      .rt_D        (rt_D),
      .Tuse_rs_D   (Tuse_rs_D),
      .Tuse_rt_D   (Tuse_rt_D),
      .md_use_D    (md_use_D),
      .regWA_E     (regWA_E),
      .RegWrite_E  (RegWrite_E),
      .Tnew_E      (Tnew_E),
      .regWA_M     (regWA_M),
      .RegWrite_M  (RegWrite_M),
      .Tnew_M      (Tnew_M),
      .md_start_E  (md_start_E),
      .md_is_div_E (md_is_div_E),
`ifdef STALL_STATS_EN
      .stall_cnt   (stall_cnt),
      .md_stall_cnt(md_stall_cnt),
`endif
      .en_pc       (en_pc),
      .en12        (en12),
      .clr_ex      (clr_ex),
      .md_busy     (md_busy),
      .stall       (stall)
   );

   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   // Reference model state: remaining busy cycles and stall tallies.
   int          busy_left = 0;
   logic [31:0] m_sc = 0, m_msc = 0;

   function automatic logic model_stall(input stim_t s, input int bl);
      int          src [2];
      int          tu  [2];
      logic        hz;
      src[0] = s.rs; tu[0] = s.tuse_rs;
      src[1] = s.rt; tu[1] = s.tuse_rt;
      hz = 1'b0;
      for (int i = 0; i < 2; i++) begin
         if (src[i] != 0 && tu[i] != 3) begin
            if (s.we_e && src[i] == s.wa_e && tu[i] < int'(s.tnew_e)) hz = 1'b1;
            if (s.we_m && src[i] == s.wa_m && tu[i] < int'(s.tnew_m)) hz = 1'b1;
         end
      end
      if (s.md_use && (bl > 0 || s.md_start)) hz = 1'b1;
      return hz;
   endfunction

   task automatic step(input stim_t s, input string tag);
      exp_t e;
      logic st, mdh;
      reset = s.reset; rs_D = s.rs; rt_D = s.rt;
      Tuse_rs_D = s.tuse_rs; Tuse_rt_D = s.tuse_rt; md_use_D = s.md_use;
      regWA_E = s.wa_e; RegWrite_E = s.we_e; Tnew_E = s.tnew_e;
      regWA_M = s.wa_m; RegWrite_M = s.we_m; Tnew_M = s.tnew_m;
      md_start_E = s.md_start; md_is_div_E = s.md_div;
      st  = model_stall(s, busy_left);
      mdh = s.md_use && (busy_left > 0 || s.md_start);
      e.stall = st; e.md_busy = (busy_left > 0);
      e.sc = m_sc; e.msc = m_msc; e.tag = tag;
      exp_q.push_back(e);
      @(posedge clk);
      if (s.reset) begin
         busy_left = 0; m_sc = 0; m_msc = 0;
      end else begin
         if (s.md_start) busy_left = s.md_div ? 10 : 5;
         else if (busy_left > 0) busy_left--;
         if (st && m_sc != 32'hFFFF_FFFF) m_sc++;
         if (mdh && m_msc != 32'hFFFF_FFFF) m_msc++;
      end
      #1;
   endtask

   function automatic stim_t idle_stim();
      stim_t s;
      s.reset = 0; s.rs = 0; s.rt = 0; s.tuse_rs = 3; s.tuse_rt = 3;
      s.md_use = 0; s.wa_e = 0; s.wa_m = 0; s.we_e = 0; s.we_m = 0;
      s.tnew_e = 0; s.tnew_m = 0; s.md_start = 0; s.md_div = 0;
      return s;
   endfunction

   // Monitor: every cycle presents a response; compare it with the queue head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (stall !== e.stall || clr_ex !== e.stall ||
                en_pc !== ~e.stall || en12 !== ~e.stall) begin
               n_fail++;
               $display("FAIL %s stall: got stall=%b en_pc=%b en12=%b clr_ex=%b, want stall=%b",
                        e.tag, stall, en_pc, en12, clr_ex, e.stall);
            end
            if (md_busy !== e.md_busy) begin
               n_fail++;
               $display("FAIL %s md_busy: got %b want %b", e.tag, md_busy, e.md_busy);
            end
`ifdef STALL_STATS_EN
            if (stall_cnt !== e.sc || md_stall_cnt !== e.msc) begin
               n_fail++;
               $display("FAIL %s stats: got %0d/%0d want %0d/%0d",
                        e.tag, stall_cnt, md_stall_cnt, e.sc, e.msc);
            end
`endif
         end
      end
   end

   initial begin
      stim_t s;
      int    guard;
      @(posedge clk); #1;

      s = idle_stim(); s.reset = 1;
      step(s, "reset0"); step(s, "reset1");
      s = idle_stim();
      step(s, "post_reset");

      // Load-use from E, then the producer moves to M with Tnew=1.
      s = idle_stim(); s.wa_e = 5; s.we_e = 1; s.tnew_e = 2; s.rs = 5; s.tuse_rs = 1;
      step(s, "load_use_E");
      s = idle_stim(); s.wa_m = 5; s.we_m = 1; s.tnew_m = 1; s.rs = 5; s.tuse_rs = 1;
      step(s, "load_use_M");
      // $0 and not-read operand.
      s = idle_stim(); s.wa_e = 0; s.we_e = 1; s.tnew_e = 2; s.rs = 0; s.tuse_rs = 0;
      step(s, "zero_reg");
      s = idle_stim(); s.wa_e = 7; s.we_e = 1; s.tnew_e = 2; s.rt = 7; s.tuse_rt = 3;
      step(s, "tuse_none");
      s = idle_stim(); s.wa_m = 7; s.we_m = 1; s.tnew_m = 2; s.rt = 7; s.tuse_rt = 1;
      step(s, "rt_M_hazard");

      // Mult: issue cycle plus 5 busy cycles stall md users, then free.
      s = idle_stim(); s.md_start = 1; s.md_use = 1;
      step(s, "mult_issue");
      s = idle_stim(); s.md_use = 1;
      for (int i = 0; i < 7; i++) step(s, "mult_busy");

      // Div with a restart on the last busy cycle (count 1): no idle gap.
      s = idle_stim(); s.md_start = 1; s.md_div = 1;
      step(s, "div_issue");
      s = idle_stim(); s.md_use = 1;
      for (int i = 0; i < 9; i++) step(s, "div_busy");
      s = idle_stim(); s.md_start = 1; s.md_use = 1;
      step(s, "div_restart");
      s = idle_stim(); s.md_use = 1;
      for (int i = 0; i < 7; i++) step(s, "mult_after_div");

      // Reset mid-divide when the count sits at 6.
      s = idle_stim(); s.md_start = 1; s.md_div = 1;
      step(s, "div2_issue");
      s = idle_stim();
      for (int i = 0; i < 4; i++) step(s, "div2_busy");
      s.reset = 1; step(s, "div2_reset");
      s = idle_stim(); s.md_use = 1;
      step(s, "after_reset");
      step(s, "after_reset2");

      // Stats scenario: 3 register stalls then 4 md stalls.
      s = idle_stim(); s.wa_e = 3; s.we_e = 1; s.tnew_e = 2; s.rs = 3; s.tuse_rs = 0;
      for (int i = 0; i < 3; i++) step(s, "stats_reg");
      s = idle_stim(); s.md_start = 1; s.md_use = 1;
      step(s, "stats_md");
      s = idle_stim(); s.md_use = 1;
      for (int i = 0; i < 3; i++) step(s, "stats_md");
      s = idle_stim();
      step(s, "stats_hold");
      s.reset = 1; step(s, "stats_reset");
      s = idle_stim();
      step(s, "stats_cleared");

      // Randomized traffic over a small register set to force collisions.
      for (int n = 0; n < 600; n++) begin
         s.reset    = ($urandom_range(0, 49) == 0);
         s.rs       = 5'($urandom_range(0, 3));
         s.rt       = 5'($urandom_range(0, 3));
         s.tuse_rs  = 2'($urandom_range(0, 3));
         s.tuse_rt  = 2'($urandom_range(0, 3));
         s.md_use   = 1'($urandom_range(0, 1));
         s.wa_e     = 5'($urandom_range(0, 3));
         s.wa_m     = 5'($urandom_range(0, 3));
         s.we_e     = 1'($urandom_range(0, 1));
         s.we_m     = 1'($urandom_range(0, 1));
         s.tnew_e   = 2'($urandom_range(0, 2));
         s.tnew_m   = 2'($urandom_range(0, 2));
         s.md_start = ($urandom_range(0, 7) == 0);
         s.md_div   = 1'($urandom_range(0, 1));
         step(s, "random");
      end

      guard = 0;
      while (exp_q.size() > 0 && guard < 20) begin
         @(posedge clk);
         guard++;
      end
      if (exp_q.size() > 0) begin
         n_fail++;
         $display("FAIL drain: %0d responses never checked, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
